// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types and encodings for the multicycle RISC-V controller
// Contents:
//   state_t                   4-bit FSM state encoding (S_FETCH = 0)
//   OP_*                      supported opcodes
//   IMM_*, RES_*, SRCA_*, SRCB_* datapath mux encodings
//   ALUOP_*, ALU_*            ALU operation class and ALU control codes
//   imm_src()                 opcode -> immediate format
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW  ? IMM_S :
               op == OP_BEQ ? IMM_B :
               op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU_Decoder: maps ALUOp and instruction fields to the 3-bit ALU control code
// Ports:
//   alu_op      in  2  operation class from the FSM (00 add, 01 sub, 10 funct)
//   funct3      in  3  IR[14:12]
//   op5         in  1  Op[5], distinguishes R-type from I-type
//   funct7b5    in  1  funct7[5]
//   alu_control out 3  ALU operation
module ALU_Decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    logic [2:0] funct_ctl;

    // funct7[5] only means subtract for R-type; in addi it is immediate bits.
    always_comb begin
        funct_ctl = ALU_ADD;
        case (funct3)
            3'b000:  funct_ctl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl = ALU_SLT;
            3'b100:  funct_ctl = ALU_XOR;
            3'b110:  funct_ctl = ALU_OR;
            3'b111:  funct_ctl = ALU_AND;
            default: funct_ctl = ALU_ADD;
        endcase
    end

    assign alu_control = alu_op == ALUOP_SUB   ? ALU_SUB :
                         alu_op == ALUOP_FUNCT ? funct_ctl : ALU_ADD;

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencing controller for the multicycle RISC-V core
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   Op, funct3, funct7  instruction fields from IR
//   Zero                ALU zero flag
//   mem_ready           shared memory completes the current access
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc            datapath mux selects
//   ALUControl          ALU operation
//   illegal             sticky unsupported-opcode flag
//   retire              one-cycle pulse when an instruction completes
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal,
    output logic       retire
);

    state_t     state, next;
    logic [1:0] alu_op;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // illegal is set on the edge that enters TRAP so it rises together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= state_t'(RESET_STATE);
            illegal <= 1'b0;
        end else begin
            state   <= next;
            illegal <= illegal | (next == S_TRAP);
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
                               Op == OP_R   ? S_EXECR :
                               Op == OP_I   ? S_EXECI :
                               Op == OP_BEQ ? S_BEQ   :
                               Op == OP_JAL ? S_JAL   : S_TRAP;
            S_MEMADR:   next = Op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next = S_FETCH;
            S_MEMWRITE: next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    next = S_ALUWB;
            S_EXECI:    next = S_ALUWB;
            S_ALUWB:    next = S_FETCH;
            S_JAL:      next = S_ALUWB;
            S_BEQ:      next = S_FETCH;
            S_TRAP:     next = S_TRAP;
            default:    next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            // Branch target OldPC+imm is computed here and held in ALUOut.
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            // PC takes the DECODE target from ALUOut while the ALU forms OldPC+4 for rd.
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_SUB;
                PCWrite = Zero;
                retire  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc = imm_src(Op);

    ALU_Decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (Op[5]),
        .funct7b5    (funct7[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    int checks = 0;
    int errors = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic z);
        mem_ready = mr;
        Zero = z;
        #1;
    endtask

    initial begin
        // reset into FETCH, memory not ready
        nxt;
        rst = 1'b0;
        drive(0, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_retire", retire, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_srcb", ALUSrcB, 2);
        chk("rst_result", ResultSrc, 2);
        nxt;
        drive(0, 0);
        chk("fetch_wait_irwrite", IRWrite, 0);

        // lw interrupted by reset in MEMREAD
        Op = 7'b0000011;
        drive(1, 0);
        chk("lwr_fetch_irwrite", IRWrite, 1);
        nxt;
        nxt;
        nxt;
        drive(0, 0);
        chk("lwr_memread_adr", AdrSrc, 1);
        rst = 1'b1;
        nxt;
        rst = 1'b0;
        drive(0, 0);
        chk("lwr_after_regwrite", RegWrite, 0);
        chk("lwr_after_illegal", illegal, 0);
        chk("lwr_after_adr", AdrSrc, 0);
        chk("lwr_after_srcb", ALUSrcB, 2);

        // add: FETCH, DECODE, EXECR, ALUWB
        Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
        drive(1, 0);
        chk("add_c1_pcwrite", PCWrite, 1);
        chk("add_c1_retire", retire, 0);
        nxt;
        drive(1, 0);
        chk("add_c2_srca", ALUSrcA, 1);
        chk("add_c2_srcb", ALUSrcB, 1);
        chk("add_c2_regwrite", RegWrite, 0);
        chk("add_c2_pcwrite", PCWrite, 0);
        nxt;
        drive(0, 0);
        chk("add_c3_aluctl", ALUControl, 0);
        chk("add_c3_srca", ALUSrcA, 2);
        chk("add_c3_srcb", ALUSrcB, 0);
        chk("add_c3_retire", retire, 0);
        nxt;
        drive(0, 0);
        chk("add_c4_regwrite", RegWrite, 1);
        chk("add_c4_retire", retire, 1);
        chk("add_c4_result", ResultSrc, 0);
        nxt;
        drive(0, 0);
        chk("add_c5_retire", retire, 0);
        chk("add_c5_srcb", ALUSrcB, 2);

        // sub (R-type, funct7[5]=1)
        funct7 = 7'b0100000;
        drive(1, 0);
        nxt;
        nxt;
        drive(0, 0);
        chk("sub_aluctl", ALUControl, 1);
        nxt;
        nxt;

        // addi with funct7 bits set: still add
        Op = 7'b0010011;
        drive(1, 0);
        nxt;
        drive(0, 0);
        chk("addi_imm", ImmSrc, 0);
        nxt;
        drive(0, 0);
        chk("addi_aluctl", ALUControl, 0);
        chk("addi_srcb", ALUSrcB, 1);
        nxt;
        drive(0, 0);
        chk("addi_retire", retire, 1);
        nxt;

        // or (R-type, funct3=110)
        Op = 7'b0110011; funct3 = 3'b110; funct7 = 7'b0000000;
        drive(1, 0);
        nxt;
        nxt;
        drive(0, 0);
        chk("or_aluctl", ALUControl, 3);
        nxt;
        nxt;
        funct3 = 3'b000;

        // lw with three not-ready cycles in MEMREAD: 8 cycles total
        Op = 7'b0000011;
        drive(1, 0);
        nxt;
        drive(0, 0);
        nxt;
        drive(0, 0);
        chk("lw_memadr_srca", ALUSrcA, 2);
        chk("lw_memadr_srcb", ALUSrcB, 1);
        for (int i = 0; i < 3; i++) begin
            nxt;
            drive(0, 0);
            chk("lw_wait_adr", AdrSrc, 1);
            chk("lw_wait_regwrite", RegWrite, 0);
        end
        nxt;
        drive(1, 0);
        chk("lw_ready_adr", AdrSrc, 1);
        nxt;
        drive(0, 0);
        chk("lw_wb_result", ResultSrc, 1);
        chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_retire", retire, 1);
        nxt;
        drive(0, 0);
        chk("lw_done_regwrite", RegWrite, 0);
        chk("lw_done_adr", AdrSrc, 0);

        // beq taken and not taken
        Op = 7'b1100011;
        drive(1, 0);
        nxt;
        drive(0, 1);
        chk("beq_dec_imm", ImmSrc, 2);
        chk("beq_dec_pcwrite", PCWrite, 0);
        nxt;
        drive(0, 1);
        chk("beq_t_pcwrite", PCWrite, 1);
        chk("beq_t_aluctl", ALUControl, 1);
        chk("beq_t_retire", retire, 1);
        nxt;
        drive(1, 0);
        nxt;
        nxt;
        drive(0, 0);
        chk("beq_nt_pcwrite", PCWrite, 0);
        chk("beq_nt_retire", retire, 1);
        nxt;
        drive(0, 0);
        chk("beq_done_retire", retire, 0);

        // sw with two not-ready cycles in MEMWRITE; mem_ready low in DECODE/MEMADR is ignored
        Op = 7'b0100011;
        drive(1, 0);
        nxt;
        drive(0, 0);
        chk("sw_imm", ImmSrc, 1);
        nxt;
        drive(0, 0);
        chk("sw_memadr_memwrite", MemWrite, 0);
        for (int i = 0; i < 2; i++) begin
            nxt;
            drive(0, 0);
            chk("sw_wait_memwrite", MemWrite, 1);
            chk("sw_wait_retire", retire, 0);
        end
        nxt;
        drive(1, 0);
        chk("sw_ready_memwrite", MemWrite, 1);
        chk("sw_ready_retire", retire, 1);
        nxt;
        drive(0, 0);
        chk("sw_done_memwrite", MemWrite, 0);
        chk("sw_done_retire", retire, 0);

        // jal: FETCH, DECODE, JAL, ALUWB
        Op = 7'b1101111;
        drive(1, 0);
        nxt;
        drive(0, 0);
        chk("jal_imm", ImmSrc, 3);
        nxt;
        drive(0, 0);
        chk("jal_pcwrite", PCWrite, 1);
        chk("jal_srca", ALUSrcA, 1);
        chk("jal_srcb", ALUSrcB, 2);
        chk("jal_regwrite", RegWrite, 0);
        nxt;
        drive(0, 0);
        chk("jal_wb_regwrite", RegWrite, 1);
        chk("jal_wb_retire", retire, 1);
        nxt;

        // unsupported opcode traps until reset
        Op = 7'b1111111;
        drive(1, 0);
        nxt;
        drive(1, 0);
        chk("trap_dec_illegal", illegal, 0);
        for (int i = 0; i < 20; i++) begin
            nxt;
            drive(1, 1);
            chk("trap_illegal", illegal, 1);
            chk("trap_enables", {PCWrite, RegWrite, MemWrite, IRWrite}, 0);
        end
        rst = 1'b1;
        nxt;
        rst = 1'b0;
        drive(0, 0);
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_srcb", ALUSrcB, 2);
        drive(1, 0);
        chk("trap_rst_irwrite", IRWrite, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
